muxer_16: RTL and testbench
===========================

// Module: muxer_16
// PURPOSE
// - 16:1 single-bit multiplexer: output q is the bit in[sel].
// - Adds a registered copy (q_r) for use on timing-critical paths.
// - Generic leaf primitive, used wherever one of 16 status/data bits is routed to a single line.
// PARAMETERS
// - N_IN   16  number of data inputs; fixed, equal to 2**SEL_W.
// - SEL_W  4   select width.
// PORTS
// - clk    input   1       clock; single clock domain; all state updates on the rising edge.
// - rst_n  input   1       reset; asynchronous, active-low.
// - in     input   16      data inputs; in[0] is selected by sel=0, in[15] by sel=15.
// - sel    input   4       binary select.
// - q      output  1       combinational in[sel].
// - q_r    output  1       q registered; 1-cycle latency.
// - par_r  output  1       registered even parity of in. Present only with MUXER_16_PARITY_EN.
// BEHAVIOUR
// - q = in[sel], purely combinational, zero latency.
// - q must settle after any change of in or sel; no latches.
// - All 16 sel codes are legal; there is no out-of-range case.
// - sel X/Z: q is don't-care in simulation; no error output is required.
// - Only in[sel] influences q. Toggling any in[k] with k != sel leaves q unchanged.
// - q_r: on rising clk, q_r <= in[sel]; it follows q with exactly 1 cycle of latency.
// - Reset: rst_n low forces q_r = 0 (and par_r = 0) immediately, without waiting for a clock edge.
// - Reset release: q_r samples q on the first rising clk after rst_n goes high.
// - Reset mid-operation: the registered outputs clear at once. q is unaffected by reset.
// - Simultaneous change of sel and in: q reflects the new in at the new sel.
// - Simultaneous change at a clock edge: q_r captures the values present before the edge (standard setup semantics).
// CONFIGURATION
// - Macro MUXER_16_PARITY_EN.
// - Defined: port par_r exists; par_r <= ^in each rising clk; reset value 0.
// - Undefined: par_r port and its logic are absent.
// - q and q_r behaviour is identical in both builds.
// STRUCTURE
// - Package muxer_16_pkg:
//   - localparams N_IN=16, SEL_W=4;
//   - typedef logic [N_IN-1:0] mux_in_t;
//   - typedef logic [SEL_W-1:0] mux_sel_t.
// - Sub-module muxer_16_mux2 (a, b, s, y) computes y = s ? b : a.
//   - muxer_16 builds a 4-level tree from 15 instances via generate:
//   - level L is driven by sel[L], with level 0 at the leaves.
// - One always_ff block holds q_r (and par_r), with asynchronous reset on negedge rst_n.
// TESTING
// - One-hot walk: for sel=0..15, drive in = 1<<sel -> q = 1.
//   - Then drive in = ~(1<<sel) -> q = 0.
//   - Covers all 32 vectors; settle 10 ns per vector.
// - Isolation: sel=4'h5, in=16'h0020. Toggle every other bit -> q stays 1.
//   - Then in=16'hFFDF -> q = 0.
// - Registered path: sel=4'hF, in=16'h8000, then one clk edge -> q_r = 1 on that edge.
//   - Change to in=16'h7FFF -> q = 0 at once; q_r = 0 only after the next edge.
// - Async reset: with q_r=1, pull rst_n low between clock edges -> q_r = 0 immediately.
//   - Release rst_n -> q_r = 1 after the first edge.
// - Parity build (MUXER_16_PARITY_EN):
//   - in=16'h0007 -> par_r = 1 after one edge;
//   - in=16'h0003 -> par_r = 0;
//   - rst_n low -> par_r = 0.
// - Random: 1000 random (in, sel) pairs -> q == in[sel].
//   - Compare q_r against the previous cycle's model value.

Source files
------------

// File: rtl/muxer_16_pkg.sv
// Shared widths, types and tree-indexing helper for the muxer_16 16:1 bit multiplexer.
package muxer_16_pkg;

    localparam int unsigned N_IN  = 16;
    localparam int unsigned SEL_W = 4;

    typedef logic [N_IN-1:0]  mux_in_t;
    typedef logic [SEL_W-1:0] mux_sel_t;

    // Tree nodes are packed level by level: leaves at 0..N_IN-1, then each level above.
    function automatic int unsigned level_base(input int unsigned lvl);
        return (2 * N_IN) - ((2 * N_IN) >> lvl);
    endfunction

endpackage

// File: rtl/muxer_16_mux2.sv
// 2:1 single-bit multiplexer leaf used to build the muxer_16 select tree.
module muxer_16_mux2 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);

    assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/muxer_16.sv
// 16:1 bit multiplexer with registered copy of the output.
// Build option MUXER_16_PARITY_EN adds a registered even-parity output par_r_o.
module muxer_16
    import muxer_16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic              q_o,
    output logic              q_r_o
`ifdef MUXER_16_PARITY_EN
    ,
    output logic              par_r_o
`endif
);

    localparam int unsigned NumNodes = 2 * N_IN - 1;

    logic [NumNodes-1:0] node;
    logic                q_r_d, q_r_q;

    assign node[N_IN-1:0] = mux_in_t'(in_i);

    // Level lvl halves the node count using sel_i[lvl]; level 0 sits at the leaves.
    for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : g_level
        localparam int unsigned InBase  = level_base(lvl);
        localparam int unsigned OutBase = level_base(lvl + 1);
        localparam int unsigned NumMux  = N_IN >> (lvl + 1);
        for (genvar i = 0; i < NumMux; i++) begin : g_mux
            muxer_16_mux2 u_mux2 (
                .a_i (node[InBase + 2 * i]),
                .b_i (node[InBase + 2 * i + 1]),
                .s_i (sel_i[lvl]),
                .y_o (node[OutBase + i])
            );
        end
    end

    assign q_o   = node[NumNodes-1];
    assign q_r_d = q_o;

`ifdef MUXER_16_PARITY_EN
    logic par_r_d, par_r_q;

    assign par_r_d = ^in_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r_q   <= 1'b0;
            par_r_q <= 1'b0;
        end else begin
            q_r_q   <= q_r_d;
            par_r_q <= par_r_d;
        end
    end

    assign par_r_o = par_r_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r_q <= 1'b0;
        end else begin
            q_r_q <= q_r_d;
        end
    end
`endif

    assign q_r_o = q_r_q;

endmodule

// File: tb/tb_muxer_16.sv
// Directed and random self-checking bench for muxer_16 (parity checks under MUXER_16_PARITY_EN).
module tb_muxer_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_v;
    logic [3:0]  sel_v;
    logic        q;
    logic        q_r;
`ifdef MUXER_16_PARITY_EN
    logic        par_r;
`endif

    int errors = 0;
    int checks = 0;

    muxer_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (in_v),
        .sel_i   (sel_v),
        .q_o     (q),
        .q_r_o   (q_r)
`ifdef MUXER_16_PARITY_EN
        ,
        .par_r_o (par_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1;
        in_v  = 16'h0008;
        sel_v = 4'd3;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (q_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_q_r: got %b want 0", q_r);
        end
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL reset_q_comb: got %b want 1", q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_onehot();
        for (int s = 0; s < 16; s++) begin
            sel_v = 4'(s);
            in_v  = 16'h1 << s;
            #10;
            checks++;
            if (q !== 1'b1) begin
                errors++;
                $display("FAIL onehot_hi sel=%0d: got %b want 1", s, q);
            end
            in_v = ~(16'h1 << s);
            #10;
            checks++;
            if (q !== 1'b0) begin
                errors++;
                $display("FAIL onehot_lo sel=%0d: got %b want 0", s, q);
            end
        end
    endtask

    task automatic test_isolation();
        sel_v = 4'h5;
        in_v  = 16'h0020;
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL iso_base: got %b want 1", q);
        end
        for (int k = 0; k < 16; k++) begin
            if (k != 5) begin
                in_v[k] = ~in_v[k];
                #1;
                checks++;
                if (q !== 1'b1) begin
                    errors++;
                    $display("FAIL iso_toggle bit=%0d: got %b want 1", k, q);
                end
            end
        end
        in_v = 16'hFFDF;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL iso_ffdf: got %b want 0", q);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        sel_v = 4'hF;
        in_v  = 16'h0000;
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_pre: got %b want 0", q_r);
        end
        in_v = 16'h8000;
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture: got %b want 1", q_r);
        end
        in_v = 16'h7FFF;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reg_q_now: got %b want 0", q);
        end
        checks++;
        if (q_r !== 1'b1) begin
            errors++;
            $display("FAIL reg_hold: got %b want 1", q_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_update: got %b want 0", q_r);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel_v = 4'hF;
        in_v  = 16'h8000;
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got %b want 1", q_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q_r !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got %b want 0", q_r);
        end
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL arst_q_unaffected: got %b want 1", q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (q_r !== 1'b0) begin
            errors++;
            $display("FAIL arst_release_hold: got %b want 0", q_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== 1'b1) begin
            errors++;
            $display("FAIL arst_release_edge: got %b want 1", q_r);
        end
    endtask

`ifdef MUXER_16_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        in_v = 16'h0007;
        @(posedge clk);
        #1;
        checks++;
        if (par_r !== 1'b1) begin
            errors++;
            $display("FAIL par_0007: got %b want 1", par_r);
        end
        in_v = 16'h0003;
        @(posedge clk);
        #1;
        checks++;
        if (par_r !== 1'b0) begin
            errors++;
            $display("FAIL par_0003: got %b want 0", par_r);
        end
        in_v = 16'h0007;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (par_r !== 1'b0) begin
            errors++;
            $display("FAIL par_reset: got %b want 0", par_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    task automatic test_random();
        logic prev_exp;
        logic prev_valid;
        logic [15:0] r_in;
        logic [3:0]  r_sel;
        prev_valid = 1'b0;
        prev_exp   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (prev_valid) begin
                checks++;
                if (q_r !== prev_exp) begin
                    errors++;
                    $display("FAIL rand_q_r iter=%0d: got %b want %b", i, q_r, prev_exp);
                end
            end
            r_in  = 16'($urandom);
            r_sel = 4'($urandom_range(15, 0));
            in_v  = r_in;
            sel_v = r_sel;
            #1;
            checks++;
            if (q !== r_in[r_sel]) begin
                errors++;
                $display("FAIL rand_q in=%h sel=%0d: got %b want %b", r_in, r_sel, q, r_in[r_sel]);
            end
            prev_exp   = r_in[r_sel];
            prev_valid = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        in_v  = 16'h0000;
        sel_v = 4'h0;
        test_reset();
        test_onehot();
        test_isolation();
        test_registered();
        test_async_reset();
`ifdef MUXER_16_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
